// File: rtl/au_rr_arbiter.sv
// au_rr_arbiter: round-robin arbiter that shares one arithmetic unit among WIDTH requesters.
// A registered one-hot grant is held until the owner releases it. Owners are always
// separated by at least one idle cycle.
// ARCH picks the prefix-OR used by the priority search: 0 serial, 1 Brent-Kung, 2 Sklansky.
// Optional build macro AU_RR_ARB_TIMEOUT_EN: forces a release after MAXHOLD grant cycles
// and adds the one-cycle timeout output pulse.
module au_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ARCH    = 0,
    parameter int MAXHOLD = 16,
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             rel,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld
`ifdef AU_RR_ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // MAXHOLD only matters with the timeout build, but it is range-checked in every build.
    if (WIDTH < 1 || ARCH < 0 || ARCH > 2 || MAXHOLD < 1) begin : g_param_check
        $error("au_rr_arbiter: illegal parameter value");
    end

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             vld_q, vld_d;

    logic [WIDTH-1:0] mask, mreq, sel, po, first;
    logic [IW-1:0]    first_idx;
    logic             normal_rel, rel_now;

`ifdef AU_RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAXHOLD + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    // LSB-first prefix OR. All three networks give the same result; they differ only in depth and fan-out.
    function automatic logic [WIDTH-1:0] prefix_or(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] p;
        p = s;
        if (ARCH == 1) begin
            // Brent-Kung: up-sweep builds power-of-two spans, down-sweep fills in the gaps.
            for (int d = 0; d < IW; d++)
                for (int i = (2 << d) - 1; i < WIDTH; i += (2 << d))
                    p[i] = p[i] | p[i - (1 << d)];
            for (int d = IW - 2; d >= 0; d--)
                for (int i = 3 * (1 << d) - 1; i < WIDTH; i += (2 << d))
                    p[i] = p[i] | p[i - (1 << d)];
        end else if (ARCH == 2) begin
            // Sklansky: each upper half-block ORs in the last bit of its lower half.
            for (int d = 0; d < IW; d++)
                for (int i = 0; i < WIDTH; i++)
                    if (((i >> d) & 1) == 1)
                        p[i] = p[i] | p[((i >> d) << d) - 1];
        end else begin
            for (int i = 1; i < WIDTH; i++)
                p[i] = p[i] | p[i - 1];
        end
        return p;
    endfunction

    // Masked first-one search: the lowest request at or above ptr wins, else the lowest overall.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++)
            mask[i] = (i >= int'(ptr_q));
        mreq  = req & mask;
        sel   = (mreq != '0) ? mreq : req;
        po    = prefix_or(sel);
        first = po & ~(po << 1);
    end

    // Encode the one-hot winner as a binary index.
    always_comb begin
        first_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (first[i]) first_idx = IW'(i);
    end

    // Next state: grant from IDLE, hold in BUSY until release (or forced release).
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        rel_now    = 1'b0;
        normal_rel = rel | ~req[idx_q];
`ifdef AU_RR_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        to_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    state_d = S_BUSY;
                    gnt_d   = first;
                    idx_d   = first_idx;
                    vld_d   = 1'b1;
                    ptr_d   = (first_idx == IW'(WIDTH - 1)) ? '0 : first_idx + IW'(1);
`ifdef AU_RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUSY: begin
                if (normal_rel) begin
                    rel_now = 1'b1;
`ifdef AU_RR_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(MAXHOLD - 1)) begin
                    rel_now = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rel_now) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
`ifdef AU_RR_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
`ifdef AU_RR_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
`ifdef AU_RR_ARB_TIMEOUT_EN
    assign timeout = to_q;
`endif

endmodule

// File: doc/au_rr_arbiter.md
Name: au_rr_arbiter

Overview:
Round-robin arbiter that shares one arithmetic unit among WIDTH requesters. It selects the next requester with a prefix-OR structure (serial, Brent-Kung or Sklansky, chosen by ARCH) that does the masked first-one detection. It registers a one-hot grant and holds it until the owner releases. It sits in front of shared AU datapaths (multiplier, divider, adder pool) as the access scheduler.

Parameters:
WIDTH, 8, number of requesters (>= 1)
ARCH, 0, prefix-OR architecture for priority search: 0 serial, 1 Brent-Kung, 2 Sklansky
MAXHOLD, 16, max grant cycles before forced release (used only with AU_RR_ARB_TIMEOUT_EN; >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req  input  WIDTH  request vector; bit i asserted by requester i while it wants or holds the unit
rel  input  1  release pulse from current owner; ignored when no grant is active
gnt  output  WIDTH  registered one-hot grant; all-zero when idle
gnt_idx  output  IW  binary index of granted requester, IW = max(ceil(log2(WIDTH)),1); 0 when idle
gnt_vld  output  1  high while a grant is active (OR of gnt)
timeout  output  1  one-cycle pulse on forced release (only with AU_RR_ARB_TIMEOUT_EN)

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset, synchronous on rst=1: state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, hold counter=0. Reset mid-grant drops the grant on the same edge.
- Internal state: ptr (IW bits, requester with highest priority) and FSM {IDLE, BUSY}.
- Priority search (combinational):
  - mask[i]=1 for i>=ptr.
  - mreq = req & mask.
  - sel = mreq if mreq!=0, else req.
  - po = prefix_or(sel), LSB-first.
  - first = po & ~(po<<1), with bit0 = po[0]. This is the lowest set bit of sel.
- IDLE:
  - If req!=0: at the next edge gnt<=first, gnt_idx<=index(first), gnt_vld<=1, ptr<=index+1 (wraps to 0 when index==WIDTH-1), state<=BUSY.
  - If req==0: outputs stay 0 and ptr is unchanged.
- BUSY:
  - Grant is held stable. req changes on other bits have no effect.
  - Release condition: rel=1, or req[gnt_idx]=0. On release, at the next edge gnt<=0, gnt_vld<=0, gnt_idx<=0, state<=IDLE.
- Latency:
  - Request to grant: 1 cycle.
  - Release to grant drop: 1 cycle.
  - Release to next grant: minimum 2 cycles. The IDLE cycle always separates owners, so there is no back-to-back handover.
- rel and a req drop in the same cycle: treated as a single release.
- rel in IDLE: ignored.
- WIDTH=1: ptr stays 0. The arbiter degenerates to grant/hold/release of bit 0.
- Fairness: a continuously requesting agent is granted within WIDTH grant cycles.

Optional Feature:
AU_RR_ARB_TIMEOUT_EN
- Defined:
  - A hold counter (ceil(log2(MAXHOLD+1)) bits) clears on grant issue and increments each BUSY cycle.
  - When the counter reaches MAXHOLD-1 in BUSY without a normal release, the block forces a release: the grant drops at the next edge and timeout=1 for exactly that one cycle (the cycle state returns to IDLE).
  - A normal release in the same cycle takes precedence, so timeout stays 0.
  - The grant is therefore active for at most MAXHOLD cycles.
- Undefined: no counter and no timeout port. The grant is held indefinitely until release.

Test Plan:
1. WIDTH=4. Assert rst for 2 cycles with req=1111 -> gnt=0000, gnt_idx=0, gnt_vld=0 during reset and on the edge after deassertion. First grant (0001) appears 1 cycle later.
2. After reset, req=0110 -> next cycle gnt=0010, gnt_idx=1, gnt_vld=1. Hold req with rel=0 for 5 cycles -> gnt stable. Pulse rel -> gnt=0000 next cycle, then gnt=0100 (idx 2) one cycle later.
3. Wrap: with ptr=3, req=1001 -> gnt=1000 (idx 3), ptr=0. Release -> gnt=0001 (idx 0).
4. Fairness: req=1111 held, owner releases each grant after 1 cycle -> grant order 0,1,2,3,0 with a 1-cycle idle gap between owners.
5. Owner drops req without rel: gnt=0100 then req[2]->0 -> gnt=0000 next cycle. rel pulse while idle -> no change.
6. AU_RR_ARB_TIMEOUT_EN, MAXHOLD=4: req=0001 held, rel=0 -> gnt_vld high for 4 cycles, then low with timeout=1 for one cycle, then regranted to 0001. Variant: rel on 4th cycle -> timeout stays 0.
